// File: rtl/i2s_audio_tx.sv
// rtl/i2s_audio_tx.sv - I2S transmitter with a 2-entry sample FIFO; each mono sample fills both slots.
module i2s_audio_tx #(
   parameter int DATA_W   = 16,
   parameter int BCLK_DIV = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              bclk,
   output logic              lrclk,
   output logic              sdata,
   output logic              underrun,
   output logic [1:0]        fifo_level
);

   localparam int DIV_W = $clog2(BCLK_DIV);
   localparam int BIT_W = $clog2(2 * DATA_W);

   logic [DIV_W-1:0]    div_cnt;
   logic [BIT_W-1:0]    bit_cnt;
   logic [BIT_W-1:0]    bit_nxt;
   logic [2*DATA_W-1:0] shreg;
   logic [DATA_W-1:0]   fifo_mem [2];
   logic [DATA_W-1:0]   head;
   logic                rd_ptr;
   logic                wr_ptr;
   logic                div_wrap;
   logic                fall;
   logic                load;
   logic                push;
   logic                pop;

   assign div_wrap = (div_cnt == DIV_W'(BCLK_DIV - 1));
   assign fall     = div_wrap && bclk;
   assign bit_nxt  = (bit_cnt == BIT_W'(2 * DATA_W - 1)) ? '0 : bit_cnt + BIT_W'(1);
   assign load     = fall && (bit_nxt == BIT_W'(1));
   assign in_ready = (fifo_level != 2'd2);
   assign push     = in_valid && in_ready;
   assign pop      = load && (fifo_level != 2'd0);
   assign head     = fifo_mem[rd_ptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_cnt  <= '0;
         bclk     <= 1'b0;
         bit_cnt  <= '0;
         lrclk    <= 1'b0;
         sdata    <= 1'b0;
         shreg    <= '0;
         underrun <= 1'b0;
      end else begin
         underrun <= load && (fifo_level == 2'd0);
         if (div_wrap) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end
         if (fall) begin
            bit_cnt <= bit_nxt;
            lrclk   <= (bit_nxt >= BIT_W'(DATA_W));
            if (load) begin
               if (fifo_level != 2'd0) begin
                  shreg <= {head, head};
                  sdata <= head[DATA_W-1];
               end else begin
                  shreg <= '0;
                  sdata <= 1'b0;
               end
            end else begin
               // the load already sent the MSB, so the next bit out sits one below it
               shreg <= shreg << 1;
               sdata <= shreg[2*DATA_W-2];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr     <= 1'b0;
         wr_ptr     <= 1'b0;
         fifo_level <= 2'd0;
      end else begin
         if (push) begin
            wr_ptr <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + 2'd1;
            2'b01:   fifo_level <= fifo_level - 2'd1;
            default: fifo_level <= fifo_level;
         endcase
      end
   end

endmodule
